// File: rtl/psram_burst_controller.sv
// ============================================================================
// Module      : psram_burst_controller
// Description : Bridges a single Wishbone-style request into one synchronous
//               CellularRAM burst (address phase, latency, data, end).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module psram_burst_controller #(
  parameter int LATENCY   = 3,
  parameter int BURST_LEN = 32
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [15:0] adr_i,
  input  logic [15:0] dat_i,
  output logic [15:0] dat_o,
  input  logic        stb_i,
  input  logic        cyc_i,
  input  logic        we_i,
  output logic        psram_clk,
  output logic [22:0] psram_adr,
  output logic [15:0] psram_dat_o,
  output logic        psram_we_n,
  output logic        psram_ce_n,
  output logic        psram_adv_n,
  output logic        psram_oe_n
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ADDR = 3'd1,
    S_LAT  = 3'd2,
    S_DATA = 3'd3,
    S_END  = 3'd4
  } state_t;

  localparam bit         c_skip_lat  = (LATENCY == 1);
  localparam logic [2:0] c_lat_last  = 3'((LATENCY > 1) ? LATENCY - 2 : 0);
  localparam logic [7:0] c_last_word = 8'(BURST_LEN - 1);

  state_t      r_state, w_state_nxt;
  logic        r_active, w_active_nxt;
  logic        r_we, w_we_nxt;
  logic [2:0]  r_lat_cnt, w_lat_cnt_nxt;
  logic [7:0]  r_word_cnt, w_word_cnt_nxt;
  logic [22:0] r_adr, w_adr_nxt;
  logic [15:0] r_dat, w_dat_nxt;
  logic [15:0] r_loop, w_loop_nxt;
  logic        r_ce_n, w_ce_n_nxt;
  logic        r_adv_n, w_adv_n_nxt;
  logic        r_we_n, w_we_n_nxt;
  logic        r_oe_n, w_oe_n_nxt;
  logic        w_req;
  logic        w_to_end;

  assign w_req = stb_i & cyc_i;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state    <= S_IDLE;
      r_active   <= 1'b0;
      r_we       <= 1'b0;
      r_lat_cnt  <= 3'd0;
      r_word_cnt <= 8'd0;
      r_adr      <= 23'd0;
      r_dat      <= 16'd0;
      r_loop     <= 16'd0;
      r_ce_n     <= 1'b1;
      r_adv_n    <= 1'b1;
      r_we_n     <= 1'b1;
      r_oe_n     <= 1'b1;
    end else begin
      r_state    <= w_state_nxt;
      r_active   <= w_active_nxt;
      r_we       <= w_we_nxt;
      r_lat_cnt  <= w_lat_cnt_nxt;
      r_word_cnt <= w_word_cnt_nxt;
      r_adr      <= w_adr_nxt;
      r_dat      <= w_dat_nxt;
      r_loop     <= w_loop_nxt;
      r_ce_n     <= w_ce_n_nxt;
      r_adv_n    <= w_adv_n_nxt;
      r_we_n     <= w_we_n_nxt;
      r_oe_n     <= w_oe_n_nxt;
    end
  end

  // Pin values are computed for the state being entered, so every strobe is
  // already valid during the first cycle of its phase.
  always_comb begin
    w_state_nxt    = r_state;
    w_active_nxt   = r_active;
    w_we_nxt       = r_we;
    w_lat_cnt_nxt  = r_lat_cnt;
    w_word_cnt_nxt = r_word_cnt;
    w_adr_nxt      = r_adr;
    w_dat_nxt      = r_dat;
    w_loop_nxt     = r_loop;
    w_ce_n_nxt     = r_ce_n;
    w_adv_n_nxt    = r_adv_n;
    w_we_n_nxt     = r_we_n;
    w_oe_n_nxt     = r_oe_n;
    w_to_end       = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (w_req) begin
          w_state_nxt    = S_ADDR;
          w_active_nxt   = 1'b1;
          w_we_nxt       = we_i;
          w_adr_nxt      = {7'b0, adr_i};
          w_ce_n_nxt     = 1'b0;
          w_adv_n_nxt    = 1'b0;
          w_we_n_nxt     = ~we_i;
          w_oe_n_nxt     = 1'b1;
          w_lat_cnt_nxt  = 3'd0;
          w_word_cnt_nxt = 8'd0;
        end
      end
      S_ADDR: begin
        w_adv_n_nxt = 1'b1;
        if (c_skip_lat) begin
          w_state_nxt = S_DATA;
          w_oe_n_nxt  = r_we;
        end else begin
          w_state_nxt   = S_LAT;
          w_lat_cnt_nxt = 3'd0;
        end
      end
      S_LAT: begin
        if (r_lat_cnt == c_lat_last) begin
          w_state_nxt = S_DATA;
          w_oe_n_nxt  = r_we;
        end else begin
          w_lat_cnt_nxt = r_lat_cnt + 3'd1;
        end
      end
      S_DATA: begin
        // A dropped request ends the burst without consuming a word.
        if (!w_req) begin
          w_to_end = 1'b1;
        end else begin
          if (r_we) begin
            w_dat_nxt  = dat_i;
            w_loop_nxt = dat_i;
          end
          w_word_cnt_nxt = r_word_cnt + 8'd1;
          if (r_word_cnt == c_last_word) begin
            w_to_end = 1'b1;
          end
        end
      end
      S_END: begin
        w_state_nxt    = S_IDLE;
        w_lat_cnt_nxt  = 3'd0;
        w_word_cnt_nxt = 8'd0;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    if (w_to_end) begin
      w_state_nxt  = S_END;
      w_active_nxt = 1'b0;
      w_ce_n_nxt   = 1'b1;
      w_adv_n_nxt  = 1'b1;
      w_we_n_nxt   = 1'b1;
      w_oe_n_nxt   = 1'b1;
    end
  end

  // Inverted clock puts the PSRAM sampling edge mid-way through each cycle.
  assign psram_clk   = ~clk_i & r_active;
  assign psram_adr   = r_adr;
  assign psram_dat_o = r_dat;
  assign dat_o       = r_loop;
  assign psram_ce_n  = r_ce_n;
  assign psram_adv_n = r_adv_n;
  assign psram_we_n  = r_we_n;
  assign psram_oe_n  = r_oe_n;

endmodule

`default_nettype wire

// File: tb/tb_psram_burst_controller.sv
// ============================================================================
// Module      : tb_psram_burst_controller
// Description : Directed and randomized bursts against a cycle-table model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_psram_burst_controller;

  localparam int L  = 3;
  localparam int BL = 32;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [15:0] adr_i, dat_i, dat_o;
  logic        stb_i, cyc_i, we_i;
  logic        psram_clk;
  logic [22:0] psram_adr;
  logic [15:0] psram_dat_o;
  logic        psram_we_n, psram_ce_n, psram_adv_n, psram_oe_n;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [22:0] exp_adr;
  logic [15:0] last_word;

  psram_burst_controller #(.LATENCY(L), .BURST_LEN(BL)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .adr_i       (adr_i),
    .dat_i       (dat_i),
    .dat_o       (dat_o),
    .stb_i       (stb_i),
    .cyc_i       (cyc_i),
    .we_i        (we_i),
    .psram_clk   (psram_clk),
    .psram_adr   (psram_adr),
    .psram_dat_o (psram_dat_o),
    .psram_we_n  (psram_we_n),
    .psram_ce_n  (psram_ce_n),
    .psram_adv_n (psram_adv_n),
    .psram_oe_n  (psram_oe_n)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, " ce_n"},  32'(psram_ce_n),  32'd1);
    check({tag, " adv_n"}, 32'(psram_adv_n), 32'd1);
    check({tag, " we_n"},  32'(psram_we_n),  32'd1);
    check({tag, " oe_n"},  32'(psram_oe_n),  32'd1);
    check({tag, " pclk"},  32'(psram_clk),   32'd0);
    check({tag, " adr"},   32'(psram_adr),   32'd0);
    check({tag, " pdat"},  32'(psram_dat_o), 32'd0);
    check({tag, " dat_o"}, 32'(dat_o),       32'd0);
  endtask

  // Expected pins in cycle c of a burst (c=0 idle before the request edge,
  // c=1 address, c=2..L latency, then dcyc data cycles, then one end cycle).
  task automatic check_cycle(input int c, input logic we, input int dcyc);
    bit act, data_ph;
    act     = (c >= 1) && (c <= L + dcyc);
    data_ph = (c >= L + 1) && (c <= L + dcyc);
    check($sformatf("ce_n c%0d", c),  32'(psram_ce_n),  32'(!act));
    check($sformatf("adv_n c%0d", c), 32'(psram_adv_n), 32'(c != 1));
    check($sformatf("we_n c%0d", c),  32'(psram_we_n),  32'(act ? !we : 1'b1));
    check($sformatf("oe_n c%0d", c),  32'(psram_oe_n),  32'((!we && data_ph) ? 1'b0 : 1'b1));
    check($sformatf("pclk c%0d", c),  32'(psram_clk),   32'(act));
    check($sformatf("adr c%0d", c),   32'(psram_adr),   32'(exp_adr));
    check($sformatf("pdat c%0d", c),  32'(psram_dat_o), 32'(last_word));
    check($sformatf("dat_o c%0d", c), 32'(dat_o),       32'(last_word));
  endtask

  task automatic drive_no_req();
    int r;
    r = $urandom_range(0, 2);
    stb_i = (r == 1);
    cyc_i = (r == 2);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk_i);
      check_cycle(0, 1'b0, 0);
      drive_no_req();
      adr_i = 16'($urandom);
      we_i  = 1'($urandom);
      dat_i = 16'($urandom);
    end
  endtask

  // The master holds stb/cyc for n_hold edges starting at the request edge.
  task automatic run_burst(input logic [15:0] adr, input logic we, input int n_hold,
                           input bit idx_data, input int abort_c);
    int          words, dcyc, last_c;
    logic [15:0] data [0:255];
    words = n_hold - L - 1;
    if (words < 0)  words = 0;
    if (words > BL) words = BL;
    dcyc   = (words < BL) ? words + 1 : words;
    last_c = L + dcyc + 1;
    for (int k = 0; k < 256; k++) data[k] = idx_data ? 16'(L + 1 + k) : 16'($urandom);
    for (int c = 0; c <= last_c; c++) begin
      @(negedge clk_i);
      if (c == 1) exp_adr = {7'b0, adr};
      if (we && (c - 1 >= L + 1) && (c - L - 2 < words)) last_word = data[c - L - 2];
      check_cycle(c, we, dcyc);
      if (c < n_hold) begin
        stb_i = 1'b1;
        cyc_i = 1'b1;
      end else begin
        drive_no_req();
      end
      adr_i = (c == 0) ? adr : 16'($urandom);
      we_i  = (c == 0) ? we  : 1'($urandom);
      dat_i = ((c >= L + 1) && (c - L - 1 < words)) ? data[c - L - 1] : 16'($urandom);
      if (c == abort_c) begin
        #2 rst_i = 1'b0;
        #1 check_reset("midrst");
        exp_adr   = 23'd0;
        last_word = 16'd0;
        return;
      end
    end
  endtask

  initial begin
    logic [15:0] trunc_adr;
    rst_i = 1'b0;
    stb_i = 1'b0;
    cyc_i = 1'b0;
    we_i  = 1'b0;
    adr_i = 16'd0;
    dat_i = 16'd0;
    exp_adr   = 23'd0;
    last_word = 16'd0;
    repeat (3) @(negedge clk_i);
    check_reset("reset");
    rst_i = 1'b1;
    idle(2);

    trunc_adr = 16'(1234567);
    run_burst(trunc_adr, 1'b1, 32, 1'b1, -1);
    idle(2);
    run_burst(16'($urandom), 1'b1, 30, 1'b1, -1);
    idle(1);
    run_burst(16'($urandom), 1'b1, 60, 1'b0, -1);
    run_burst(16'($urandom), 1'b0, 40, 1'b0, -1);
    run_burst(16'($urandom), 1'b0, 1, 1'b0, -1);

    for (int i = 0; i < 10; i++) begin
      run_burst(16'($urandom), 1'($urandom), $urandom_range(1, 45), 1'b0, -1);
      idle($urandom_range(0, 2));
    end

    run_burst(16'($urandom), 1'b1, 40, 1'b0, L + 6);
    @(negedge clk_i);
    check_reset("inrst");
    stb_i = 1'b0;
    cyc_i = 1'b0;
    rst_i = 1'b1;
    idle(1);
    run_burst(16'($urandom), 1'b1, 12, 1'b0, -1);
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/psram_burst_controller.md
Name: psram_burst_controller

Overview:
- Bus-slave bridge that turns a Wishbone-style request (`stb_i`/`cyc_i`/`we_i`) into one synchronous burst on a CellularRAM-type PSRAM.
- Drives the PSRAM clock, address and control strobes, plus the write-data bus.
- Sits between the system bus and the external PSRAM pins.
- This revision has no PSRAM data-input path and no WAIT input.

Parameters:
- LATENCY, 3, PSRAM clocks between the address-latch cycle and the first data word (range 1..7).
- BURST_LEN, 32, maximum words per burst (range 1..255).

Ports:
- `clk_i`  in  1  system clock; all registers update on the rising edge.
- `rst_i`  in  1  asynchronous, active-low reset.
- `adr_i`  in  16  word start address, sampled on the request cycle.
- `dat_i`  in  16  write data, one word per DATA cycle.
- `dat_o`  out  16  loopback of the last word driven to the PSRAM.
- `stb_i`  in  1  strobe.
- `cyc_i`  in  1  bus cycle valid.
- `we_i`  in  1  1 = write burst, 0 = read burst.
- `psram_clk`  out  1  PSRAM clock: ~`clk_i` while a burst is active, else 0.
- `psram_adr`  out  23  PSRAM address, {7'b0, latched `adr_i`}.
- `psram_dat_o`  out  16  PSRAM write data.
- `psram_we_n`  out  1  active-low write enable.
- `psram_ce_n`  out  1  active-low chip enable.
- `psram_adv_n`  out  1  active-low address valid.
- `psram_oe_n`  out  1  active-low output enable.

Behaviour:
- Reset (`rst_i`=0, asynchronous):
  - state=IDLE.
  - `psram_ce_n`, `psram_adv_n`, `psram_we_n`, `psram_oe_n` = 1.
  - `psram_adr`=0, `psram_dat_o`=0, `dat_o`=0.
  - Burst active flag=0, so `psram_clk`=0.
  - Counters = 0.
- Reset mid-burst aborts the burst immediately with the same values.
- `psram_clk` is combinational: `clk_i` inverted, gated by the registered active flag. This puts PSRAM sampling edges mid-cycle relative to output updates.
- All other outputs are registered.
- IDLE:
  - Strobes are high.
  - On a rising edge with `stb_i` & `cyc_i` = 1: latch `adr_i` and `we_i`, set active, go to ADDR.
- ADDR (1 cycle):
  - `psram_ce_n`=0, `psram_adv_n`=0.
  - `psram_we_n`=~we (latched).
  - `psram_adr`={7'b0, adr}.
  - Next state is LAT.
- LAT (LATENCY-1 cycles, counted by `lat_cnt`):
  - `psram_adv_n`=1, `psram_ce_n`=0, `psram_we_n` held.
  - Bus data is ignored.
  - When done, go to DATA.
  - With LATENCY=1, skip LAT and go ADDR to DATA.
- DATA:
  - Write burst: each cycle `psram_dat_o` <= `dat_i` and `dat_o` <= `dat_i`; `psram_oe_n`=1.
  - Read burst: `psram_oe_n`=0, `psram_dat_o` unchanged.
  - The word counter increments every DATA cycle.
  - The master presents word k (k=0..) in the (LATENCY+1+k)-th cycle after the request edge.
  - Leave DATA, going to END, when the counter reaches BURST_LEN, or when `stb_i` or `cyc_i` is 0 at a rising edge. The termination cycle transfers no word.
- END (1 cycle):
  - `psram_ce_n`=1, `psram_we_n`=1, `psram_oe_n`=1, `psram_adv_n`=1.
  - Clear active, go to IDLE.
- A new request is accepted only in IDLE, giving at least one idle cycle between bursts.
- `psram_adr` stays constant during a burst; the PSRAM increments its address internally. Address wrap-around is the PSRAM's concern.
- `adr_i` values above 16 bits are truncated by the bus, e.g. 1234567 arrives as 0xD687.
- Requests arriving while `stb_i`/`cyc_i` toggle in ADDR or LAT are not aborted. Termination is checked only in DATA.

Test Plan:
- Reset: hold `rst_i`=0 and toggle the clock -> all `psram_*_n`=1, `psram_clk`=0, `psram_adr`=0, `dat_o`=0.
- Write burst request: `adr_i`=0xD687, `we_i`=1, `stb_i`=`cyc_i`=1, held for 32 cycles.
  - Next cycle: `psram_ce_n`=0, `psram_adv_n`=0, `psram_we_n`=0, `psram_adr`=0x00D687.
  - 3 cycles later the DATA phase starts.
- Same write burst: data words equal the cycle index -> `psram_dat_o`/`dat_o` track `dat_i`; `psram_oe_n`=1 throughout.
- Early stop: drop `stb_i`/`cyc_i` after 30 total request cycles -> DATA ends at the next edge, then one END cycle with `psram_ce_n`=1, `psram_clk` gated low, then IDLE.
- Length limit: hold the request for 60 cycles -> exactly BURST_LEN=32 DATA cycles, then END, then a new burst is accepted only after IDLE.
- Read burst with `we_i`=0 -> `psram_we_n`=1, `psram_oe_n`=0 in DATA, `psram_dat_o` unchanged.
- Reset mid-burst: assert `rst_i`=0 during DATA -> all outputs return to reset values without waiting for a clock edge.
